// File: rtl/fir_da_sequencer_if.sv
// Output valid/ready channel of the DA FIR sequencer.
// The master side presents completed filter results; the slave side accepts them.
interface fir_da_sequencer_if #(
  parameter int ACC_W = 32
);
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/fir_da_sequencer.sv
// Per-sample controller for the 64-tap distributed-arithmetic FIR core (clk3 domain).
// Optional build macro FIR_SEQ_STATUS_EN adds saturating sample_cnt/stall_cnt status outputs.
module fir_da_sequencer #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int RD_LAT = 1,
  parameter int BIT_W  = 4
) (
  input  logic               clk3,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               fifo_empty,
  output logic               fifo_read,
  output logic               tap_shift,
  output logic               sreg_load,
  output logic               da_clr,
  output logic               da_en,
  output logic               da_sign,
  output logic [BIT_W-1:0]   bit_idx,
  input  logic [ACC_W-1:0]   da_sum,
  output logic               busy,
`ifdef FIR_SEQ_STATUS_EN
  output logic [15:0]        sample_cnt,
  output logic [15:0]        stall_cnt,
`endif
  fir_da_sequencer_if.master out_if
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_LOAD, S_CALC, S_DRAIN, S_OUT
  } state_e;

  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [1:0]       WAIT_LAST = 2'((RD_LAT > 0) ? RD_LAT - 1 : 0);

  state_e           state_q, state_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [1:0]       wait_q, wait_d;
  logic [ACC_W-1:0] data_q, data_d;
  logic             fetchable;

  assign fetchable = enable & ~fifo_empty;

  always_comb begin
    // NOTE: every _d gets its hold value first; a path that left one unassigned would infer a latch.
    state_d = state_q;
    bit_d   = bit_q;
    wait_d  = wait_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE:  if (fetchable) state_d = S_FETCH;
      S_FETCH: begin
        wait_d  = '0;
        state_d = (RD_LAT == 0) ? S_LOAD : S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == WAIT_LAST) state_d = S_LOAD;
        else                     wait_d  = wait_q + 2'd1;
      end
      S_LOAD: begin
        bit_d   = '0;
        state_d = S_CALC;
      end
      S_CALC: begin
        if (bit_q == BIT_LAST) state_d = S_DRAIN;
        else                   bit_d   = bit_q + 1'b1;
      end
      // One extra cycle lets the DA accumulator's output register settle before capture.
      S_DRAIN: begin
        data_d  = da_sum;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (out_if.out_ready) state_d = fetchable ? S_FETCH : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk3) begin
    // NOTE: non-blocking so every register samples the values from before this edge.
    if (!reset_n) begin
      state_q <= S_IDLE;
      bit_q   <= '0;
      wait_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      wait_q  <= wait_d;
      data_q  <= data_d;
    end
  end

  // Strobes decode purely from registered state: no input-to-output paths.
  assign fifo_read        = (state_q == S_FETCH);
  assign tap_shift        = (state_q == S_LOAD);
  assign sreg_load        = (state_q == S_LOAD);
  assign da_clr           = (state_q == S_LOAD);
  assign da_en            = (state_q == S_CALC);
  assign da_sign          = (state_q == S_CALC) && (bit_q == BIT_LAST);
  assign bit_idx          = bit_q;
  assign busy             = (state_q != S_IDLE);
  assign out_if.out_valid = (state_q == S_OUT);
  assign out_if.out_data  = data_q;

`ifdef FIR_SEQ_STATUS_EN
  logic [15:0] sample_cnt_q, sample_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    sample_cnt_d = sample_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (state_q == S_OUT) begin
      if (out_if.out_ready && sample_cnt_q != 16'hFFFF) sample_cnt_d = sample_cnt_q + 16'd1;
      if (!out_if.out_ready && stall_cnt_q != 16'hFFFF) stall_cnt_d  = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk3) begin
    if (!reset_n) begin
      sample_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      sample_cnt_q <= sample_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign sample_cnt = sample_cnt_q;
  assign stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fir_da_sequencer.sv
// Scoreboard bench for fir_da_sequencer: RD_LAT=1 main instance plus RD_LAT=0/3 latency instances.
// Compile with +define+FIR_SEQ_STATUS_EN to also check the status counters.
`timescale 1ns/1ps
module tb_fir_da_sequencer;
  localparam int DATA_W = 16;
  localparam int ACC_W  = 32;
  localparam int BIT_W  = 4;
  localparam int NDUT   = 3;   // index 0: RD_LAT=0, 1: RD_LAT=1 (main), 2: RD_LAT=3

  logic clk3 = 1'b0;
  always #5 clk3 = ~clk3;

  logic             reset_n;
  logic             enable;
  logic             out_ready;
  logic             fifo_empty;
  logic [ACC_W-1:0] da_base  = '0;
  logic [ACC_W-1:0] da_noise = '0;
  logic [ACC_W-1:0] da_sum;
  int               pushed_total = 0;
  int               read_total   = 0;

  assign da_sum     = da_base ^ da_noise;
  assign fifo_empty = (pushed_total == read_total);

  logic [NDUT-1:0]  fr, ts, sl, dc, de, ds, by, ov;
  logic [BIT_W-1:0] bi [NDUT];
`ifdef FIR_SEQ_STATUS_EN
  logic [15:0]      sc [NDUT];
  logic [15:0]      stc [NDUT];
`endif

  fir_da_sequencer_if #(.ACC_W(ACC_W)) if0 ();
  fir_da_sequencer_if #(.ACC_W(ACC_W)) if1 ();
  fir_da_sequencer_if #(.ACC_W(ACC_W)) if3 ();

  assign if0.out_ready = 1'b1;
  assign if1.out_ready = out_ready;
  assign if3.out_ready = 1'b1;
  assign ov = {if3.out_valid, if1.out_valid, if0.out_valid};

  fir_da_sequencer #(.DATA_W(DATA_W), .ACC_W(ACC_W), .RD_LAT(0), .BIT_W(BIT_W)) u_lat0 (
    .clk3(clk3), .reset_n(reset_n), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_read(fr[0]), .tap_shift(ts[0]), .sreg_load(sl[0]), .da_clr(dc[0]),
    .da_en(de[0]), .da_sign(ds[0]), .bit_idx(bi[0]), .da_sum(da_sum), .busy(by[0]),
`ifdef FIR_SEQ_STATUS_EN
    .sample_cnt(sc[0]), .stall_cnt(stc[0]),
`endif
    .out_if(if0.master)
  );

  fir_da_sequencer #(.DATA_W(DATA_W), .ACC_W(ACC_W), .RD_LAT(1), .BIT_W(BIT_W)) u_dut (
    .clk3(clk3), .reset_n(reset_n), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_read(fr[1]), .tap_shift(ts[1]), .sreg_load(sl[1]), .da_clr(dc[1]),
    .da_en(de[1]), .da_sign(ds[1]), .bit_idx(bi[1]), .da_sum(da_sum), .busy(by[1]),
`ifdef FIR_SEQ_STATUS_EN
    .sample_cnt(sc[1]), .stall_cnt(stc[1]),
`endif
    .out_if(if1.master)
  );

  fir_da_sequencer #(.DATA_W(DATA_W), .ACC_W(ACC_W), .RD_LAT(3), .BIT_W(BIT_W)) u_lat3 (
    .clk3(clk3), .reset_n(reset_n), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_read(fr[2]), .tap_shift(ts[2]), .sreg_load(sl[2]), .da_clr(dc[2]),
    .da_en(de[2]), .da_sign(ds[2]), .bit_idx(bi[2]), .da_sum(da_sum), .busy(by[2]),
`ifdef FIR_SEQ_STATUS_EN
    .sample_cnt(sc[2]), .stall_cnt(stc[2]),
`endif
    .out_if(if3.master)
  );

  int total = 0;
  int bad   = 0;

  int cyc = 0;
  always @(posedge clk3) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard state: stimulus pushes, monitor pops.
  logic [ACC_W-1:0] exp_q [$];
  logic [ACC_W-1:0] da_q  [$];
  int               hs_cyc [$];
  int               rd_c [NDUT];
  int               ld_c [NDUT];
  int               ov_c [NDUT];
  logic [NDUT-1:0]  ov_prev = '0;
  int               rd_pulses = 0;
  int               load_cnt  = 0;
  int               hs_cnt    = 0;
  int               idle_cnt  = 0;
  int               da_en_cnt = 0;
  int               exp_bit   = 0;

  always @(negedge clk3) begin
    for (int k = 0; k < NDUT; k++) begin
      if (fr[k]) rd_c[k] = cyc;
      if (ts[k]) ld_c[k] = cyc;
      if (ov[k] && !ov_prev[k]) ov_c[k] = cyc;
    end
    if (fr[1]) begin
      check("no_empty_read", 64'(read_total < pushed_total), 1);
      rd_pulses++;
      if (read_total < pushed_total) read_total++;
    end
    if (ts[1] || sl[1] || dc[1]) begin
      check("load_strobes", {ts[1], sl[1], dc[1]}, 3'b111);
      load_cnt++;
      exp_bit   = 0;
      da_en_cnt = 0;
      if (da_q.size() > 0) da_base = da_q.pop_front();
    end
    if (de[1]) begin
      check("bit_idx", bi[1], exp_bit);
      check("da_sign", ds[1], 64'(exp_bit == DATA_W - 1));
      exp_bit++;
      da_en_cnt++;
    end
    if (ov[1] && !ov_prev[1]) check("da_en_count", da_en_cnt, DATA_W);
    if (ov[1] && out_ready) begin
      hs_cnt++;
      hs_cyc.push_back(cyc);
      check("exp_avail", 64'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check("out_data", if1.out_data, exp_q.pop_front());
    end
    if (!by[1]) idle_cnt++;
    ov_prev = ov;
  end

  task automatic tick();
    @(posedge clk3);
    #2;
  endtask

  task automatic push_sample(input logic [ACC_W-1:0] v, input bit expect_out);
    da_q.push_back(v);
    if (expect_out) exp_q.push_back(v);
    pushed_total++;
  endtask

  task automatic wait_hs(input int target, input int budget, input string name);
    int n = 0;
    while (hs_cnt < target && n < budget) begin
      tick();
      n++;
    end
    if (hs_cnt < target) check({name, "_timeout"}, hs_cnt, target);
  endtask

  task automatic wait_sig(input int idx_kind, input int budget, input string name);
    int  n = 0;
    bit  hit;
    hit = (idx_kind == 0) ? ov[1] : de[1];
    while (!hit && n < budget) begin
      tick();
      n++;
      hit = (idx_kind == 0) ? ov[1] : de[1];
    end
    if (!hit) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    int n, m, rd0, ld0, h0, idle0;
    logic [ACC_W-1:0] vec [4];
    vec[0] = 32'h0000_0001; vec[1] = 32'hFFFF_FFFF; vec[2] = 32'h8000_0000; vec[3] = 32'h5A5A_A5A5;

    enable    = 1'b0;
    out_ready = 1'b1;
    da_noise  = '0;
    do_reset();
    check("rst_busy",      by[1], 0);
    check("rst_valid",     ov[1], 0);
    check("rst_bit_idx",   bi[1], 0);
    check("rst_strobes",   {fr[1], ts[1], de[1], ds[1]}, 0);
    check("rst_out_data",  if1.out_data, 0);

    // Single sample: latency on all three read-latency builds.
    for (int k = 0; k < NDUT; k++) begin
      rd_c[k] = -1; ld_c[k] = -1; ov_c[k] = -1;
    end
    enable = 1'b1;
    push_sample(32'h1234_5678, 1'b1);
    n = cyc;
    repeat (30) tick();
    check("t2_hs_count", hs_cnt, 1);
    check("t2_read_lat0", rd_c[0], n + 1);
    check("t2_read_lat1", rd_c[1], n + 1);
    check("t2_read_lat3", rd_c[2], n + 1);
    check("t2_load_lat0", ld_c[0], n + 2);
    check("t2_load_lat1", ld_c[1], n + 3);
    check("t2_load_lat3", ld_c[2], n + 5);
    check("t2_valid_lat0", ov_c[0], n + 20);
    check("t2_valid_lat1", ov_c[1], n + 21);
    check("t2_valid_lat3", ov_c[2], n + 23);
    check("t2_data_lat0", if0.out_data, 32'h1234_5678);
    check("t2_data_lat3", if3.out_data, 32'h1234_5678);
    check("t2_idle_after", by[1], 0);

    // Back-to-back: four queued samples, out_ready held high.
    rd0 = rd_pulses; ld0 = load_cnt; h0 = hs_cnt;
    for (int i = 0; i < 4; i++) push_sample(vec[i], 1'b1);
    tick();
    idle0 = idle_cnt;
    wait_hs(h0 + 4, 120, "t3_hs");
    check("t3_no_idle", idle_cnt - idle0, 0);
    check("t3_reads", rd_pulses - rd0, 4);
    check("t3_shifts", load_cnt - ld0, 4);
    for (int i = 1; i < 4; i++)
      if (hs_cyc.size() > h0 + i) check("t3_spacing", hs_cyc[h0 + i] - hs_cyc[h0 + i - 1], 21);

    // Backpressure: 10 stalled cycles while da_sum wiggles, with a second sample waiting.
    do_reset();
    out_ready = 1'b0;
    h0 = hs_cnt;
    push_sample(32'hCAFE_0001, 1'b1);
    push_sample(32'h0BAD_F00D, 1'b1);
    wait_sig(0, 40, "t4_valid");
    rd0 = rd_pulses; ld0 = load_cnt;
    m = cyc;
    for (int i = 0; i < 10; i++) begin
      da_noise = $urandom;
      check("t4_stall_data", if1.out_data, 32'hCAFE_0001);
      check("t4_stall_valid", ov[1], 1);
      tick();
    end
    da_noise = '0;
    check("t4_no_read", rd_pulses - rd0, 0);
    check("t4_no_shift", load_cnt - ld0, 0);
    out_ready = 1'b1;
    tick();
    check("t4_hs_cycle", (hs_cyc.size() > h0) ? hs_cyc[h0] : -1, m + 10);
`ifdef FIR_SEQ_STATUS_EN
    check("t4_sample_cnt", sc[1], 1);
    check("t4_stall_cnt", stc[1], 10);
`endif
    wait_hs(h0 + 2, 40, "t4_second");

    // enable drops mid-sample: current output still delivered, then no fetch.
    rd0 = rd_pulses; h0 = hs_cnt;
    push_sample(32'h7654_3210, 1'b1);
    push_sample(32'h0F0F_0F0F, 1'b0);
    wait_sig(1, 20, "t5_calc");
    enable = 1'b0;
    wait_hs(h0 + 1, 40, "t5_hs");
    repeat (30) tick();
    check("t5_one_read", rd_pulses - rd0, 1);
    check("t5_idle", by[1], 0);
    check("t5_fifo_left", pushed_total - read_total, 1);
    exp_q.push_back(32'h0F0F_0F0F);
    enable = 1'b1;
    wait_hs(h0 + 2, 40, "t5_resume");
    check("t5_two_reads", rd_pulses - rd0, 2);

    // Reset during CALC discards the sample in flight.
    h0 = hs_cnt;
    push_sample(32'hDEAD_BEEF, 1'b0);
    wait_sig(1, 20, "t1_calc");
    reset_n = 1'b0;
    tick();
    check("t1_busy_in_rst", by[1], 0);
    check("t1_en_in_rst", de[1], 0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check("t1_busy", by[1], 0);
    check("t1_valid", ov[1], 0);
    check("t1_bit_idx", bi[1], 0);
    check("t1_out_data", if1.out_data, 0);
    repeat (25) tick();
    check("t1_no_output", hs_cnt - h0, 0);
    enable = 1'b0;

    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
